// File: rtl/bytecode_sequencer.sv
// Bytecode sequencer: fetches opcode/argument bytes from program memory, issues
// UNARY/BINARY operations to an external combinational ALU, and handles JMP/HALT.
module bytecode_sequencer #(
    parameter int unsigned          DATA_W     = 8,
    parameter int unsigned          ADDR_W     = 10,
    parameter int unsigned          OP_W       = 6,
    parameter logic [ADDR_W-1:0]    START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_valid,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              running,
    output logic              halted,
    output logic              error,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, EXEC, HALT, ERR} state_e;

    localparam logic [DATA_W-1:0] OPC_UNARY  = DATA_W'(8'h01);
    localparam logic [DATA_W-1:0] OPC_BINARY = DATA_W'(8'h02);
    localparam logic [DATA_W-1:0] OPC_JMP    = DATA_W'(8'h03);
    localparam logic [DATA_W-1:0] OPC_HALT   = DATA_W'(8'hFF);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   opc_q, opc_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                rv_q, rv_d;
    logic [2*DATA_W-1:0] jmp_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            idx_q    <= '0;
            opc_q    <= '0;
            lo_q     <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            idx_q    <= idx_d;
            opc_q    <= opc_d;
            lo_q     <= lo_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            rv_q     <= rv_d;
        end
    end

    // idx_q counts the byte position within the current instruction (0 = opcode).
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        idx_d    = idx_q;
        opc_d    = opc_q;
        lo_d     = lo_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        rv_d     = 1'b0;
        jmp_tgt  = {mem_rdata, lo_q};
        unique case (state_q)
            IDLE, HALT, ERR: begin
                if (start) begin
                    pc_d    = START_ADDR;
                    idx_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = DATA;
            DATA: begin
                pc_d    = pc_q + ADDR_W'(1);
                idx_d   = idx_q + 2'd1;
                state_d = ADDR;
                unique case (idx_q)
                    2'd0: begin
                        opc_d = mem_rdata;
                        if (mem_rdata == OPC_HALT) begin
                            state_d = HALT;
                        end else if (mem_rdata != OPC_UNARY && mem_rdata != OPC_BINARY &&
                                     mem_rdata != OPC_JMP) begin
                            state_d = ERR;
                        end
                    end
                    2'd1: begin
                        if (opc_q == OPC_JMP) begin
                            lo_d = mem_rdata;
                        end else begin
                            op_d = OP_W'(mem_rdata);
                            if (opc_q == OPC_UNARY) begin
                                b_d = '0;
                            end
                        end
                    end
                    2'd2: begin
                        if (opc_q == OPC_JMP) begin
                            pc_d  = ADDR_W'(jmp_tgt);
                            idx_d = '0;
                        end else begin
                            a_d = mem_rdata;
                            if (opc_q == OPC_UNARY) begin
                                state_d = EXEC;
                            end
                        end
                    end
                    default: begin
                        b_d     = mem_rdata;
                        state_d = EXEC;
                    end
                endcase
            end
            EXEC: begin
                result_d = alu_result;
                rv_d     = 1'b1;
                idx_d    = '0;
                state_d  = ADDR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        running   = 1'b0;
        alu_valid = 1'b0;
        halted    = 1'b0;
        error     = 1'b0;
        unique case (state_q)
            ADDR, DATA: running = 1'b1;
            EXEC: begin
                running   = 1'b1;
                alu_valid = 1'b1;
            end
            HALT:    halted = 1'b1;
            ERR:     error  = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr     = pc_q;
    assign pc           = pc_q;
    assign alu_op       = op_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign result       = result_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_bytecode_sequencer.sv
// Bench for bytecode_sequencer: directed vector table, hand-written corner cases,
// and random programs checked against an instruction-level interpreter.
module tb_bytecode_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       st    [2];
    logic [9:0] maddr [2];
    logic [7:0] rdata [2];
    logic [5:0] aop   [2];
    logic [7:0] aa    [2];
    logic [7:0] ab    [2];
    logic       av    [2];
    logic [7:0] ares  [2];
    logic [7:0] res   [2];
    logic       rv    [2];
    logic       runn  [2];
    logic       hlt   [2];
    logic       err   [2];
    logic [9:0] pcw   [2];

    logic [7:0] mem [1024];

    function automatic logic [7:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        return a + (b ^ {2'b00, op});
    endfunction

    bytecode_sequencer #(.DATA_W(8), .ADDR_W(10), .OP_W(6), .START_ADDR(10'h000)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .mem_addr(maddr[0]), .mem_rdata(rdata[0]),
        .alu_op(aop[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_valid(av[0]), .alu_result(ares[0]),
        .result(res[0]), .result_valid(rv[0]), .running(runn[0]), .halted(hlt[0]),
        .error(err[0]), .pc(pcw[0])
    );

    bytecode_sequencer #(.DATA_W(8), .ADDR_W(10), .OP_W(6), .START_ADDR(10'h3FE)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .mem_addr(maddr[1]), .mem_rdata(rdata[1]),
        .alu_op(aop[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_valid(av[1]), .alu_result(ares[1]),
        .result(res[1]), .result_valid(rv[1]), .running(runn[1]), .halted(hlt[1]),
        .error(err[1]), .pc(pcw[1])
    );

    always @(posedge clk) begin
        rdata[0] <= mem[maddr[0]];
        rdata[1] <= mem[maddr[1]];
    end
    assign ares[0] = alu_f(aop[0], aa[0], ab[0]);
    assign ares[1] = alu_f(aop[1], aa[1], ab[1]);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs(input int s);
        return {9'd0, maddr[s], aop[s], aa[s], ab[s], av[s], res[s], rv[s], runn[s], hlt[s], err[s], pcw[s]};
    endfunction

    // Reference interpreter: walks the program instruction by instruction and
    // derives each alu_valid cycle from the 2-cycle-per-byte fetch rule.
    typedef struct {
        int         cyc;
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } txn_t;

    txn_t exp_q[$];
    int   exp_stop, exp_pc;
    logic exp_halt, exp_err;

    task automatic model(input int sa);
        int pc, t;
        logic [7:0] opc, x, y, z;
        bit done;
        exp_q.delete();
        pc = sa; t = 1; done = 0;
        exp_halt = 0; exp_err = 0; exp_stop = -1; exp_pc = -1;
        for (int k = 0; k < 200 && !done; k++) begin
            opc = mem[pc]; pc = (pc + 1) % 1024;
            case (opc)
                8'h01: begin
                    x = mem[pc]; pc = (pc + 1) % 1024;
                    y = mem[pc]; pc = (pc + 1) % 1024;
                    exp_q.push_back(txn_t'{t + 6, x[5:0], y, 8'h00});
                    t += 7;
                end
                8'h02: begin
                    x = mem[pc]; pc = (pc + 1) % 1024;
                    y = mem[pc]; pc = (pc + 1) % 1024;
                    z = mem[pc]; pc = (pc + 1) % 1024;
                    exp_q.push_back(txn_t'{t + 8, x[5:0], y, z});
                    t += 9;
                end
                8'h03: begin
                    x = mem[pc]; pc = (pc + 1) % 1024;
                    y = mem[pc];
                    pc = (int'(y) * 256 + int'(x)) % 1024;
                    t += 6;
                end
                8'hFF: begin
                    exp_halt = 1; exp_pc = pc; exp_stop = t + 2; done = 1;
                end
                default: begin
                    exp_err = 1; exp_pc = pc; exp_stop = t + 2; done = 1;
                end
            endcase
        end
    endtask

    int         obs_n, obs_first;
    logic [5:0] obs_op;
    logic [7:0] obs_a, obs_b;

    task automatic run_prog(input int sel, input int poke);
        txn_t e;
        int stop, pend_cyc, extra;
        bit pend;
        logic [7:0] pend_res;
        model(sel ? 'h3FE : 0);
        obs_n = 0; obs_first = -1; pend = 0; stop = -1; pend_cyc = 0; pend_res = '0;
        @(negedge clk);
        st[sel] = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            st[sel] = (c == poke);
            if (pend && c == pend_cyc + 1) begin
                check("result_valid", rv[sel], 1);
                check("result", res[sel], pend_res);
                pend = 0;
            end else if (rv[sel]) begin
                check("result_valid_extra", 1, 0);
            end
            if (av[sel]) begin
                obs_n++;
                if (obs_first < 0) obs_first = c;
                obs_op = aop[sel]; obs_a = aa[sel]; obs_b = ab[sel];
                if (exp_q.size() == 0) begin
                    check("alu_valid_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("alu_cycle", c, e.cyc);
                    check("alu_operands", {aop[sel], aa[sel], ab[sel]}, {e.op, e.a, e.b});
                    pend = 1; pend_cyc = c; pend_res = alu_f(e.op, e.a, e.b);
                end
            end
            if (hlt[sel] || err[sel]) begin
                stop = c;
                break;
            end
        end
        st[sel] = 1'b0;
        check("stop_cycle", stop, exp_stop);
        check("halted", hlt[sel], exp_halt);
        check("error", err[sel], exp_err);
        check("pc_final", pcw[sel], exp_pc);
        check("running_stopped", runn[sel], 0);
        check("alu_valid_missing", exp_q.size(), 0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            extra += int'(av[sel]) + int'(rv[sel]);
        end
        check("quiet_after_stop", extra, 0);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h5A;
    endtask

    typedef struct {
        int              sel;
        int              len;
        logic [0:7][7:0] prog;
        int              xaddr;
        logic [7:0]      xbyte;
        int              poke;
        logic            halt;
        logic            err;
        int              pc;
        int              n_alu;
        logic [5:0]      op;
        logic [7:0]      a;
        logic [7:0]      b;
        int              lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base, p, n, kind, gap, extra;
        bit bad;
        logic [9:0] tgt;

        // lat = cycles strictly between the opcode ADDR cycle and alu_valid
        vecs[0] = '{0, 5, {8'h02, 8'h05, 8'h0A, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h00}, -1, 8'h00, 0, 1, 0, 5,     1, 6'h05, 8'h0A, 8'h03, 7};
        vecs[1] = '{0, 4, {8'h01, 8'h07, 8'h22, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 8'h00, 0, 1, 0, 4,     1, 6'h07, 8'h22, 8'h00, 5};
        vecs[2] = '{0, 3, {8'h03, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 'h10, 8'hFF, 0, 1, 0, 'h11, 0, 6'h00, 8'h00, 8'h00, 0};
        vecs[3] = '{0, 1, {8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 8'h00, 0, 0, 1, 1,     0, 6'h00, 8'h00, 8'h00, 0};
        vecs[4] = '{1, 5, {8'h02, 8'h01, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h00}, -1, 8'h00, 0, 1, 0, 3,     1, 6'h01, 8'hAA, 8'h55, 7};
        vecs[5] = '{0, 4, {8'h01, 8'hC7, 8'h22, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 8'h00, 3, 1, 0, 4,     1, 6'h07, 8'h22, 8'h00, 5};
        vecs[6] = '{0, 8, {8'h02, 8'h09, 8'h11, 8'h22, 8'h01, 8'h03, 8'h44, 8'hFF}, -1, 8'h00, 0, 1, 0, 8,     2, 6'h03, 8'h44, 8'h00, 7};

        fill_mem();
        rst = 1'b1; st[0] = 1'b1; st[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs_dut0", all_outs(0), 0);
        check("reset_outputs_dut1", all_outs(1), 0);
        rst = 1'b0; st[0] = 1'b0; st[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_not_running", {runn[0], runn[1]}, 0);

        for (int i = 0; i < 7; i++) begin
            fill_mem();
            base = vecs[i].sel ? 'h3FE : 0;
            for (int j = 0; j < vecs[i].len; j++) mem[(base + j) % 1024] = vecs[i].prog[j];
            if (vecs[i].xaddr >= 0) mem[vecs[i].xaddr] = vecs[i].xbyte;
            run_prog(vecs[i].sel, vecs[i].poke);
            check($sformatf("v%0d_halted", i), hlt[vecs[i].sel], vecs[i].halt);
            check($sformatf("v%0d_error", i), err[vecs[i].sel], vecs[i].err);
            check($sformatf("v%0d_pc", i), pcw[vecs[i].sel], vecs[i].pc);
            check($sformatf("v%0d_alu_count", i), obs_n, vecs[i].n_alu);
            if (vecs[i].n_alu > 0) begin
                check($sformatf("v%0d_last_operands", i), {obs_op, obs_a, obs_b},
                      {vecs[i].op, vecs[i].a, vecs[i].b});
                check($sformatf("v%0d_latency", i), obs_first - 2, vecs[i].lat);
            end
        end

        // Restart out of ERR: flags clear and pc reloads on the start edge.
        fill_mem();
        run_prog(0, 0);
        @(negedge clk); st[0] = 1'b1;
        @(negedge clk); st[0] = 1'b0;
        check("restart_error_cleared", err[0], 0);
        check("restart_running", runn[0], 1);
        check("restart_pc", pcw[0], 0);
        repeat (4) @(negedge clk);
        check("restart_errors_again", err[0], 1);

        // Reset during the a-byte fetch of a BINARY instruction.
        fill_mem();
        mem[0] = 8'h02; mem[1] = 8'h05; mem[2] = 8'h0A; mem[3] = 8'h03; mem[4] = 8'hFF;
        @(negedge clk); st[0] = 1'b1;
        @(negedge clk); st[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_running_before", runn[0], 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs_zero", all_outs(0), 0);
        rst = 1'b0;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            extra += int'(av[0]) + int'(rv[0]) + int'(runn[0]);
        end
        check("midrst_stays_idle", extra, 0);

        // Random programs, alternating between the two start addresses.
        for (int i = 0; i < 24; i++) begin
            fill_mem();
            base = (i % 2) ? 'h3FE : 0;
            p = base; bad = 0;
            n = $urandom_range(1, 5);
            for (int k = 0; k < n && !bad; k++) begin
                kind = $urandom_range(0, 9);
                if (kind <= 3) begin
                    mem[p % 1024] = 8'h01; mem[(p + 1) % 1024] = 8'($urandom);
                    mem[(p + 2) % 1024] = 8'($urandom); p += 3;
                end else if (kind <= 7) begin
                    mem[p % 1024] = 8'h02; mem[(p + 1) % 1024] = 8'($urandom);
                    mem[(p + 2) % 1024] = 8'($urandom); mem[(p + 3) % 1024] = 8'($urandom); p += 4;
                end else if (kind == 8) begin
                    gap = $urandom_range(0, 3);
                    tgt = 10'((p + 3 + gap) % 1024);
                    mem[p % 1024] = 8'h03; mem[(p + 1) % 1024] = tgt[7:0];
                    mem[(p + 2) % 1024] = {6'($urandom), tgt[9:8]};
                    p += 3 + gap;
                end else begin
                    mem[p % 1024] = 8'(4 + $urandom_range(0, 250));
                    p += 1; bad = 1;
                end
            end
            if (!bad) mem[p % 1024] = 8'hFF;
            run_prog(i % 2, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 20)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
